sc_lost_referee_two_players: RTL and testbench
==============================================

Name: sc_lost_referee_two_players

Overview:
- Sequential consumer of the two-player collision comparator's active-low "lost" flag. It is the receiving end of that signal.
- Samples the flag once per game frame and confirms a collision over consecutive frames. On each confirmed hit it decrements the shared lives count, runs a display blink sequence, freezes game logic, and waits for a restart button.
- Sits between the comparator and the game datapath / LED-matrix display driver.

Parameters:
- LIVES, 3, lives loaded at reset and on restart after game over (1..2^LIVESWIDTH-1).
- LIVESWIDTH, 2, width of the lives counter and output bus.
- FILTER_FRAMES, 2, consecutive frames with lost asserted needed to confirm a hit (>=1).
- BLINK_FRAMES, 8, frames the blink sequence lasts after a hit.
- CNTWIDTH, 4, width of the filter and blink counters (must hold max(FILTER_FRAMES, BLINK_FRAMES)).

Ports:
- SC_LOST_REFEREE_CLOCK_50  in  1  system clock.
- SC_LOST_REFEREE_RESET_InLow  in  1  asynchronous active-low reset.
- SC_LOST_REFEREE_lost_InLow  in  1  comparator output; 0 = players overlap this frame.
- SC_LOST_REFEREE_frameTick_InHigh  in  1  one-cycle pulse marking the frame boundary; lost is valid in that cycle.
- SC_LOST_REFEREE_restart_InLow  in  1  debounced, synchronized restart button; 0 = pressed.
- SC_LOST_REFEREE_lives_OutBUS  out  LIVESWIDTH  remaining lives.
- SC_LOST_REFEREE_freeze_OutHigh  out  1  1 = game datapath must hold position registers.
- SC_LOST_REFEREE_displayOn_OutHigh  out  1  0 = blank the matrix (blink phase).
- SC_LOST_REFEREE_hit_OutHigh  out  1  one-cycle pulse per confirmed hit.
- SC_LOST_REFEREE_gameOver_OutHigh  out  1  1 while in GAME_OVER.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs are registered and change one cycle after the causing input.
- Reset values: state=PLAY, lives=LIVES, freeze=0, displayOn=1, hit=0, gameOver=0. Filter and blink counters = 0; restart edge register = 1.
- Restart edge: previous restart_InLow is registered. A press is the falling edge (prev=1, now=0). Holding the button produces only one press.
- PLAY:
  - lost_InLow is sampled only when frameTick=1. Between ticks it is ignored, so mid-frame glitches from the combinational comparator are ignored.
  - Tick with lost=0: filter count +1. Tick with lost=1: filter count cleared.
  - When the count reaches FILTER_FRAMES: go to HIT, clear the filter count.
  - Presses are ignored.
- HIT (exactly one cycle):
  - hit pulses 1, lives decrements (saturates at 0, never wraps), freeze=1.
  - Blink counter cleared, displayOn=0. Go to BLINK.
- BLINK:
  - Each tick toggles displayOn and increments the blink counter.
  - On the tick where the counter reaches BLINK_FRAMES: displayOn forced to 1. If lives==0 go to GAME_OVER, else go to WAIT.
  - freeze stays 1. Presses are ignored.
- WAIT: freeze=1, displayOn=1. A press goes to PLAY: freeze=0, filter cleared. Ticks are ignored.
- GAME_OVER: gameOver=1, freeze=1, displayOn=1. A press reloads lives=LIVES, clears gameOver, goes to PLAY.
- Simultaneous events:
  - Tick and press in the same cycle in WAIT/GAME_OVER: the press wins and the tick is discarded.
  - Tick with lost=0 in the same cycle as the HIT entry is not possible, because HIT lasts one cycle with no tick sampling.
- Reset mid-operation (any state, including BLINK with display blanked): immediate return to the reset values. Lives are reloaded.
- FILTER_FRAMES=1: the first tick with lost=0 confirms the hit.

Decomposition:
- Shared game package holds:
  - state encoding constants: PLAY=3'd0, HIT=3'd1, BLINK=3'd2, WAIT=3'd3, GAME_OVER=3'd4;
  - default LIVES/FILTER_FRAMES/BLINK_FRAMES constants, reused by the score/display blocks.
- One natural sub-module, sc_frame_counter: a parameterized up-counter with clear, enable (frameTick) and terminal-count compare. It is instantiated twice (filter and blink).
- The FSM, lives register and edge detector live in the top.

Test Plan:
- Reset, then 5 ticks with lost=1 -> lives=3, freeze=0, displayOn=1, no hit pulse.
- Ticks with lost=0,1,0,1 (alternating) -> never confirmed, lives stays 3. Then two consecutive lost=0 ticks -> hit pulse one cycle after the 2nd tick, lives=2, freeze=1, displayOn=0.
- After a hit: 8 ticks -> displayOn toggles each tick, =1 after the 8th, state WAIT. Press restart held 20 cycles -> exactly one transition to PLAY, freeze=0.
- Three confirmed hits with restarts in between -> lives 3→2→1→0, after the third blink gameOver=1. Extra ticks with lost=0 -> lives stays 0. Press -> lives=3, gameOver=0.
- In WAIT, press and tick in the same cycle -> PLAY entered, filter count 0 (a lost=0 tick on the next frame alone does not hit).
- Assert reset mid-BLINK (displayOn=0, lives=1) -> asynchronously displayOn=1, freeze=0, lives=3, state PLAY.

Source files
------------

// File: rtl/sc_lost_referee_two_players_pkg.sv
// rtl/sc_lost_referee_two_players_pkg.sv - shared game constants and referee state encoding
package sc_lost_referee_two_players_pkg;

  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    HIT       = 3'd1,
    BLINK     = 3'd2,
    WAIT      = 3'd3,
    GAME_OVER = 3'd4
  } refState_t;

  // Defaults shared with the score and display blocks
  localparam int DEFAULT_LIVES         = 3;
  localparam int DEFAULT_LIVESWIDTH    = 2;
  localparam int DEFAULT_FILTER_FRAMES = 2;
  localparam int DEFAULT_BLINK_FRAMES  = 8;
  localparam int DEFAULT_CNTWIDTH      = 4;

endpackage

// File: rtl/sc_frame_counter.sv
// rtl/sc_frame_counter.sv - frame up-counter with clear, enable and terminal-count strobe
module sc_frame_counter #(
  parameter int CNTWIDTH = 4,
  parameter int TERMINAL = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNTWIDTH-1:0] LAST = CNTWIDTH'(TERMINAL - 1);

  logic [CNTWIDTH-1:0] count;

  // done marks the enabled frame on which the count reaches TERMINAL; the count then restarts
  assign done = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sc_lost_referee_two_players.sv
// rtl/sc_lost_referee_two_players.sv - frame-filtered collision referee with lives, blink and restart
module sc_lost_referee_two_players
  import sc_lost_referee_two_players_pkg::*;
#(
  parameter int LIVES         = DEFAULT_LIVES,
  parameter int LIVESWIDTH    = DEFAULT_LIVESWIDTH,
  parameter int FILTER_FRAMES = DEFAULT_FILTER_FRAMES,
  parameter int BLINK_FRAMES  = DEFAULT_BLINK_FRAMES,
  parameter int CNTWIDTH      = DEFAULT_CNTWIDTH
) (
  input  logic                  SC_LOST_REFEREE_CLOCK_50,
  input  logic                  SC_LOST_REFEREE_RESET_InLow,
  input  logic                  SC_LOST_REFEREE_lost_InLow,
  input  logic                  SC_LOST_REFEREE_frameTick_InHigh,
  input  logic                  SC_LOST_REFEREE_restart_InLow,
  output logic [LIVESWIDTH-1:0] SC_LOST_REFEREE_lives_OutBUS,
  output logic                  SC_LOST_REFEREE_freeze_OutHigh,
  output logic                  SC_LOST_REFEREE_displayOn_OutHigh,
  output logic                  SC_LOST_REFEREE_hit_OutHigh,
  output logic                  SC_LOST_REFEREE_gameOver_OutHigh
);

  localparam logic [LIVESWIDTH-1:0] LIVES_INIT = LIVESWIDTH'(LIVES);

  logic clk;
  logic rstN;
  logic tick;
  logic lost;

  assign clk  = SC_LOST_REFEREE_CLOCK_50;
  assign rstN = SC_LOST_REFEREE_RESET_InLow;
  assign tick = SC_LOST_REFEREE_frameTick_InHigh;
  assign lost = ~SC_LOST_REFEREE_lost_InLow;

  refState_t             state,     stateNext;
  logic [LIVESWIDTH-1:0] lives,     livesNext;
  logic                  freeze,    freezeNext;
  logic                  displayOn, displayOnNext;
  logic                  hit,       hitNext;
  logic                  gameOver,  gameOverNext;
  logic                  restartPrev;
  logic                  press;

  logic filterClr, filterEn, filterDone;
  logic blinkClr,  blinkEn,  blinkDone;

  // A press is the released-to-pressed transition, so a held button counts once
  assign press = restartPrev & ~SC_LOST_REFEREE_restart_InLow;

  // Overlap is only trusted on the frame boundary; mid-frame comparator glitches never reach the filter
  assign filterEn  = (state == PLAY) && tick && lost;
  assign filterClr = (state != PLAY) || (tick && !lost);
  assign blinkEn   = (state == BLINK) && tick;
  assign blinkClr  = (state == PLAY) || (state == HIT);

  sc_frame_counter #(
    .CNTWIDTH (CNTWIDTH),
    .TERMINAL (FILTER_FRAMES)
  ) filterCounter (
    .clk    (clk),
    .rstN   (rstN),
    .clear  (filterClr),
    .enable (filterEn),
    .done   (filterDone)
  );

  sc_frame_counter #(
    .CNTWIDTH (CNTWIDTH),
    .TERMINAL (BLINK_FRAMES)
  ) blinkCounter (
    .clk    (clk),
    .rstN   (rstN),
    .clear  (blinkClr),
    .enable (blinkEn),
    .done   (blinkDone)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= PLAY;
      lives       <= LIVES_INIT;
      freeze      <= 1'b0;
      displayOn   <= 1'b1;
      hit         <= 1'b0;
      gameOver    <= 1'b0;
      restartPrev <= 1'b1;
    end else begin
      state       <= stateNext;
      lives       <= livesNext;
      freeze      <= freezeNext;
      displayOn   <= displayOnNext;
      hit         <= hitNext;
      gameOver    <= gameOverNext;
      restartPrev <= SC_LOST_REFEREE_restart_InLow;
    end
  end

  // Outputs are computed as next-register values so they settle with the state they belong to
  always_comb begin
    stateNext     = state;
    livesNext     = lives;
    freezeNext    = freeze;
    displayOnNext = displayOn;
    hitNext       = 1'b0;
    gameOverNext  = gameOver;

    case (state)
      PLAY: begin
        freezeNext    = 1'b0;
        displayOnNext = 1'b1;
        gameOverNext  = 1'b0;
        if (filterDone) begin
          stateNext     = HIT;
          hitNext       = 1'b1;
          livesNext     = (lives == '0) ? '0 : lives - 1'b1;
          freezeNext    = 1'b1;
          displayOnNext = 1'b0;
        end
      end

      HIT: begin
        stateNext     = BLINK;
        freezeNext    = 1'b1;
        displayOnNext = 1'b0;
      end

      BLINK: begin
        freezeNext = 1'b1;
        if (blinkEn) begin
          displayOnNext = ~displayOn;
          if (blinkDone) begin
            displayOnNext = 1'b1;
            if (lives == '0) begin
              stateNext    = GAME_OVER;
              gameOverNext = 1'b1;
            end else begin
              stateNext = WAIT;
            end
          end
        end
      end

      WAIT: begin
        freezeNext    = 1'b1;
        displayOnNext = 1'b1;
        if (press) begin
          stateNext  = PLAY;
          freezeNext = 1'b0;
        end
      end

      GAME_OVER: begin
        freezeNext    = 1'b1;
        displayOnNext = 1'b1;
        gameOverNext  = 1'b1;
        if (press) begin
          stateNext    = PLAY;
          livesNext    = LIVES_INIT;
          freezeNext   = 1'b0;
          gameOverNext = 1'b0;
        end
      end

      default: begin
        stateNext     = PLAY;
        livesNext     = LIVES_INIT;
        freezeNext    = 1'b0;
        displayOnNext = 1'b1;
        gameOverNext  = 1'b0;
      end
    endcase
  end

  assign SC_LOST_REFEREE_lives_OutBUS      = lives;
  assign SC_LOST_REFEREE_freeze_OutHigh    = freeze;
  assign SC_LOST_REFEREE_displayOn_OutHigh = displayOn;
  assign SC_LOST_REFEREE_hit_OutHigh       = hit;
  assign SC_LOST_REFEREE_gameOver_OutHigh  = gameOver;

endmodule

// File: tb/tb_sc_lost_referee_two_players.sv
// tb/tb_sc_lost_referee_two_players.sv - self-checking bench for the collision referee
module tb_sc_lost_referee_two_players;

  localparam int LIVES  = 3;
  localparam int FILTER = 2;
  localparam int BLINK  = 8;

  logic       clk = 1'b0;
  logic       rstN;
  logic       lostIn;
  logic       frameTick;
  logic       restartIn;
  logic [1:0] lives;
  logic       freeze;
  logic       displayOn;
  logic       hit;
  logic       gameOver;

  int         nAssert = 0;
  int         nFail   = 0;
  int         hitCount = 0;
  int         hitBase;
  int         mLives;
  logic       hitAtTick;
  logic [1:0] livesAtTick;
  logic       freezeAtTick;
  logic       dispAtTick;

  sc_lost_referee_two_players dut (
    .SC_LOST_REFEREE_CLOCK_50          (clk),
    .SC_LOST_REFEREE_RESET_InLow       (rstN),
    .SC_LOST_REFEREE_lost_InLow        (lostIn),
    .SC_LOST_REFEREE_frameTick_InHigh  (frameTick),
    .SC_LOST_REFEREE_restart_InLow     (restartIn),
    .SC_LOST_REFEREE_lives_OutBUS      (lives),
    .SC_LOST_REFEREE_freeze_OutHigh    (freeze),
    .SC_LOST_REFEREE_displayOn_OutHigh (displayOn),
    .SC_LOST_REFEREE_hit_OutHigh       (hit),
    .SC_LOST_REFEREE_gameOver_OutHigh  (gameOver)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock with the given inputs; outputs are looked at 1 time unit after the edge
  task automatic step(input logic tk, input logic ls, input logic rs);
    frameTick = tk;
    lostIn    = ls;
    restartIn = rs;
    @(posedge clk);
    #1;
    frameTick = 1'b0;
    if (hit === 1'b1) hitCount++;
  endtask

  // A frame: the tick cycle followed by idle cycles carrying random comparator glitches
  task automatic frame(input logic ls, input logic rs);
    step(1'b1, ls, rs);
    hitAtTick    = hit;
    livesAtTick  = lives;
    freezeAtTick = freeze;
    dispAtTick   = displayOn;
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), rs);
  endtask

  // Display is dark right after a hit and flips each frame, but is always lit after the last one
  task automatic blinkFrames(input int n);
    for (int k = 1; k <= n; k++) begin
      frame(1'($urandom_range(0, 1)), 1'b1);
      check("blinkDisplay", 32'(dispAtTick), (k == BLINK) ? 32'd1 : 32'(k % 2));
      check("blinkFreeze", 32'(freezeAtTick), 32'd1);
    end
  endtask

  // Random lost pattern until FILTER consecutive overlapping frames have been seen
  task automatic playRound();
    int   run   = 0;
    logic found = 1'b0;
    logic ls;
    hitBase = hitCount;
    for (int f = 0; f < 60 && !found; f++) begin
      ls = 1'($urandom_range(0, 1));
      frame(ls, 1'b1);
      run = ls ? 0 : run + 1;
      check("roundHitAtTick", 32'(hitAtTick), (run == FILTER) ? 32'd1 : 32'd0);
      if (run == FILTER) found = 1'b1;
    end
    check("roundHitFound", 32'(found), 32'd1);
    mLives = (mLives == 0) ? 0 : mLives - 1;
    check("roundLives", 32'(lives), 32'(mLives));
    check("roundHitPulses", 32'(hitCount - hitBase), 32'd1);
  endtask

  task automatic press();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rstN      = 1'b0;
    lostIn    = 1'b1;
    frameTick = 1'b0;
    restartIn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstLives", 32'(lives), 32'(LIVES));
    check("rstFreeze", 32'(freeze), 32'd0);
    check("rstDisplay", 32'(displayOn), 32'd1);
    check("rstHit", 32'(hit), 32'd0);
    check("rstGameOver", 32'(gameOver), 32'd0);
    rstN = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b1);

    repeat (5) frame(1'b1, 1'b1);
    check("idleLives", 32'(lives), 32'(LIVES));
    check("idleFreeze", 32'(freeze), 32'd0);
    check("idleDisplay", 32'(displayOn), 32'd1);
    check("idleHits", 32'(hitCount), 32'd0);

    frame(1'b0, 1'b1);
    frame(1'b1, 1'b1);
    frame(1'b0, 1'b1);
    frame(1'b1, 1'b1);
    check("altHits", 32'(hitCount), 32'd0);
    check("altLives", 32'(lives), 32'(LIVES));

    frame(1'b0, 1'b1);
    check("firstTickNoHit", 32'(hitAtTick), 32'd0);
    frame(1'b0, 1'b1);
    check("hitPulse", 32'(hitAtTick), 32'd1);
    check("hitLives", 32'(livesAtTick), 32'd2);
    check("hitFreeze", 32'(freezeAtTick), 32'd1);
    check("hitDisplay", 32'(dispAtTick), 32'd0);
    check("hitOneCycle", 32'(hitCount), 32'd1);
    mLives = 2;

    blinkFrames(BLINK);
    check("waitGameOver", 32'(gameOver), 32'd0);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    check("waitIgnoresTicks", 32'(hitCount), 32'd1);
    check("waitFreeze", 32'(freeze), 32'd1);

    // Press lands on a lost=0 tick and is held for the rest of this block
    frame(1'b0, 1'b0);
    check("pressUnfreeze", 32'(freezeAtTick), 32'd0);
    frame(1'b0, 1'b0);
    check("discardedTickNoHit", 32'(hitAtTick), 32'd0);
    frame(1'b0, 1'b0);
    check("heldHit", 32'(hitAtTick), 32'd1);
    check("heldLives", 32'(livesAtTick), 32'd1);
    mLives = 1;
    for (int k = 1; k <= BLINK; k++) begin
      frame(1'($urandom_range(0, 1)), 1'b0);
      check("heldBlinkDisplay", 32'(dispAtTick), (k == BLINK) ? 32'd1 : 32'(k % 2));
    end
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    check("heldNoSecondPress", 32'(freeze), 32'd1);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("pressToPlay", 32'(freeze), 32'd0);
    repeat (19) step(1'b0, 1'b1, 1'b0);
    check("holdStaysPlay", 32'(freeze), 32'd0);
    step(1'b0, 1'b1, 1'b1);

    playRound();
    blinkFrames(BLINK);
    check("overFlag", 32'(gameOver), 32'd1);
    check("overDisplay", 32'(displayOn), 32'd1);
    check("overFreeze", 32'(freeze), 32'd1);
    hitBase = hitCount;
    repeat (3) frame(1'b0, 1'b1);
    check("overLivesSat", 32'(lives), 32'd0);
    check("overNoHits", 32'(hitCount - hitBase), 32'd0);
    press();
    check("restartLives", 32'(lives), 32'(LIVES));
    check("restartGameOver", 32'(gameOver), 32'd0);
    check("restartFreeze", 32'(freeze), 32'd0);
    mLives = LIVES;

    playRound();
    blinkFrames(BLINK);
    check("round2GameOver", 32'(gameOver), 32'd0);
    press();
    playRound();
    blinkFrames(2);
    check("midBlinkDisplay", 32'(displayOn), 32'd0);
    check("midBlinkLives", 32'(lives), 32'd1);

    #2 rstN = 1'b0;
    #1;
    check("asyncRstDisplay", 32'(displayOn), 32'd1);
    check("asyncRstFreeze", 32'(freeze), 32'd0);
    check("asyncRstLives", 32'(lives), 32'(LIVES));
    check("asyncRstGameOver", 32'(gameOver), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b1);
    frame(1'b0, 1'b1);
    check("postRstHit", 32'(hitAtTick), 32'd1);
    check("postRstLives", 32'(livesAtTick), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
